// File: rtl/store_narrow_rmw.sv
`default_nettype none
// ============================================================================
// Module   : store_narrow_rmw
// Purpose  : Store unit that turns word/halfword/byte stores into full-word
//            memory writes. Aligned word stores are written directly;
//            halfword and byte stores do a read-modify-write of the
//            containing word. Misaligned or reserved-size requests are
//            rejected with a one-cycle error pulse.
// Ports    : clk          - clock, rising edge
//            rst_n        - asynchronous active-low reset
//            req          - store request valid (sampled only while idle)
//            size         - 00 word, 01 halfword, 10 byte, 11 reserved
//            addr         - byte address of the store
//            wr_data      - store data (half uses [15:0], byte uses [7:0])
//            busy         - request not accepted, hold req and operands
//            mem_addr     - word-aligned memory address (0 when idle)
//            mem_read     - one-cycle memory read strobe
//            mem_rd_data  - read data, valid the cycle after mem_read
//            mem_write    - one-cycle memory write strobe
//            mem_wr_data  - full word to write (0 when not writing)
//            byte_en      - lanes modified by this store (0 when not writing)
//            done         - one-cycle completion pulse
//            align_err    - one-cycle pulse for a rejected request
// Revision : 1.0 - initial release
// ============================================================================
module store_narrow_rmw (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic [1:0]  size,
   input  logic [31:0] addr,
   input  logic [31:0] wr_data,
   output logic        busy,
   output logic [31:0] mem_addr,
   output logic        mem_read,
   input  logic [31:0] mem_rd_data,
   output logic        mem_write,
   output logic [31:0] mem_wr_data,
   output logic [3:0]  byte_en,
   output logic        done,
   output logic        align_err
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_MERGE = 3'd2,
      S_WRITE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [1:0] C_SIZE_WORD = 2'b00;
   localparam logic [1:0] C_SIZE_HALF = 2'b01;
   localparam logic [1:0] C_SIZE_BYTE = 2'b10;

   state_t      r_state;
   state_t      w_next;
   logic [29:0] r_word_addr;
   logic [31:0] r_data;       // replicated store data, later the merged word
   logic [3:0]  r_be;
   logic        r_align_err;

   logic        w_legal;
   logic        w_accept;
   logic        w_reject;
   logic [3:0]  w_be;
   logic [31:0] w_rep;
   logic [31:0] w_mask;
   logic [31:0] w_merged;

   // Request decode. Narrow data is replicated into every lane so that the
   // merge is a plain lane-mask select against the read word.
   always_comb begin
      w_legal = 1'b0;
      w_be    = 4'b0000;
      w_rep   = 32'h0;
      case (size)
         C_SIZE_WORD: begin
            w_legal = (addr[1:0] == 2'b00);
            w_be    = 4'b1111;
            w_rep   = wr_data;
         end
         C_SIZE_HALF: begin
            w_legal = ~addr[0];
            w_be    = addr[1] ? 4'b1100 : 4'b0011;
            w_rep   = {2{wr_data[15:0]}};
         end
         C_SIZE_BYTE: begin
            w_legal = 1'b1;
            w_be    = 4'b0001 << addr[1:0];
            w_rep   = {4{wr_data[7:0]}};
         end
         default: begin
            w_legal = 1'b0;
         end
      endcase
   end

   assign w_accept = (r_state == S_IDLE) && req && w_legal;
   assign w_reject = (r_state == S_IDLE) && req && !w_legal;

   assign w_mask   = {{8{r_be[3]}}, {8{r_be[2]}}, {8{r_be[1]}}, {8{r_be[0]}}};
   assign w_merged = (mem_rd_data & ~w_mask) | (r_data & w_mask);

   // State register and operand latches
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_word_addr <= 30'h0;
         r_data      <= 32'h0;
         r_be        <= 4'b0000;
         r_align_err <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_align_err <= w_reject;
         if (w_accept) begin
            r_word_addr <= addr[31:2];
            r_data      <= w_rep;
            r_be        <= w_be;
         end else if (r_state == S_MERGE) begin
            r_data      <= w_merged;
         end
      end
   end

   // Next state and outputs
   always_comb begin
      w_next      = r_state;
      busy        = 1'b1;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      mem_wr_data = 32'h0;
      byte_en     = 4'b0000;
      done        = 1'b0;
      mem_addr    = 32'h0;
      align_err   = r_align_err;
      case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            if (w_accept) begin
               // Full-word stores need no read of the old contents
               w_next = (w_be == 4'b1111) ? S_WRITE : S_READ;
            end
         end
         S_READ: begin
            mem_read = 1'b1;
            mem_addr = {r_word_addr, 2'b00};
            w_next   = S_MERGE;
         end
         S_MERGE: begin
            mem_addr = {r_word_addr, 2'b00};
            w_next   = S_WRITE;
         end
         S_WRITE: begin
            mem_write   = 1'b1;
            mem_wr_data = r_data;
            byte_en     = r_be;
            mem_addr    = {r_word_addr, 2'b00};
            w_next      = S_DONE;
         end
         S_DONE: begin
            done   = 1'b1;
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_store_narrow_rmw.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_narrow_rmw
// Purpose  : Self-checking bench for store_narrow_rmw. The driver pushes the
//            expected memory events (kind, cycle, address, data, lanes) into
//            a queue when it issues a store; a monitor pops and compares on
//            every observed strobe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_store_narrow_rmw;

   localparam int K_READ  = 0;
   localparam int K_WRITE = 1;
   localparam int K_DONE  = 2;
   localparam int K_ERR   = 3;

   logic        clk;
   logic        rst_n;
   logic        req;
   logic [1:0]  size;
   logic [31:0] addr;
   logic [31:0] wr_data;
   logic        busy;
   logic [31:0] mem_addr;
   logic        mem_read;
   logic [31:0] mem_rd_data;
   logic        mem_write;
   logic [31:0] mem_wr_data;
   logic [3:0]  byte_en;
   logic        done;
   logic        align_err;

   store_narrow_rmw dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .size        (size),
      .addr        (addr),
      .wr_data     (wr_data),
      .busy        (busy),
      .mem_addr    (mem_addr),
      .mem_read    (mem_read),
      .mem_rd_data (mem_rd_data),
      .mem_write   (mem_write),
      .mem_wr_data (mem_wr_data),
      .byte_en     (byte_en),
      .done        (done),
      .align_err   (align_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edge counter: after rising edge n has been processed, cyc == n
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          kind;
      int          cyc;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
   } ev_t;

   ev_t q[$];

   int checks = 0;
   int passes = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic push(input int kind, input int c, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be);
      ev_t e;
      e.kind = kind; e.cyc = c; e.addr = a; e.data = d; e.be = be;
      q.push_back(e);
   endtask

   task automatic observe(input int kind);
      ev_t e;
      if (q.size() == 0) begin
         checks++;
         $display("FAIL unexpected_event actual=kind%0d required=none (cycle %0d)", kind, cyc);
      end else begin
         e = q.pop_front();
         chk("event_kind", kind, e.kind);
         chk("event_cycle", cyc, e.cyc);
         case (kind)
            K_READ: chk("read_addr", mem_addr, e.addr);
            K_WRITE: begin
               chk("write_addr", mem_addr, e.addr);
               chk("write_data", mem_wr_data, e.data);
               chk("write_be", {28'h0, byte_en}, {28'h0, e.be});
            end
            K_ERR: chk("err_busy", {31'h0, busy}, 32'h0);
            default: ;
         endcase
      end
   endtask

   // Monitor: samples on the falling edge, away from the active edge
   always @(negedge clk) begin
      if (rst_n) begin
         chk("invariants",
             {29'h0, mem_read & mem_write,
              !mem_write && (mem_wr_data != 32'h0 || byte_en != 4'h0),
              !busy && (mem_addr != 32'h0)},
             32'h0);
         if (mem_read)  observe(K_READ);
         if (mem_write) observe(K_WRITE);
         if (done)      observe(K_DONE);
         if (align_err) observe(K_ERR);
      end
   end

   // Stimulus vector: sub selects read-modify-write, err selects rejection
   typedef struct {
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] rd;
      int          mode;      // 0 word, 1 sub-word, 2 rejected
      logic [31:0] exp_data;
      logic [3:0]  exp_be;
   } vec_t;

   // Called at the drive point (#2 after a rising edge) with the DUT idle
   task automatic issue(input vec_t v);
      int t;
      logic [31:0] wa;
      req = 1'b1; size = v.size; addr = v.addr; wr_data = v.data; mem_rd_data = v.rd;
      t  = cyc + 1;
      wa = {v.addr[31:2], 2'b00};
      case (v.mode)
         0: begin
            push(K_WRITE, t, wa, v.exp_data, v.exp_be);
            push(K_DONE, t + 1, 32'h0, 32'h0, 4'h0);
         end
         1: begin
            push(K_READ, t, wa, 32'h0, 4'h0);
            push(K_WRITE, t + 2, wa, v.exp_data, v.exp_be);
            push(K_DONE, t + 3, 32'h0, 32'h0, 4'h0);
         end
         default: push(K_ERR, t, 32'h0, 32'h0, 4'h0);
      endcase
      @(posedge clk); #2;
      req = 1'b0; addr = 32'hFFFF_FFFF; wr_data = 32'h5555_5555;
   endtask

   task automatic drain(input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (q.size() == 0 && !busy) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #2;
      end
      checks++;
      if (ok) passes++;
      else $display("FAIL %s_timeout actual=pending%0d required=pending0", name, q.size());
   endtask

   vec_t vecs[10];

   initial begin
      vecs[0] = '{2'b00, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0000, 0, 32'hDEAD_BEEF, 4'b1111};
      vecs[1] = '{2'b10, 32'h0000_0203, 32'h0000_00AB, 32'h1122_3344, 1, 32'hAB22_3344, 4'b1000};
      vecs[2] = '{2'b01, 32'h0000_0302, 32'hFFFF_5A5A, 32'h1122_3344, 1, 32'h5A5A_3344, 4'b1100};
      vecs[3] = '{2'b01, 32'h0000_0301, 32'h0000_1234, 32'h0000_0000, 2, 32'h0, 4'b0000};
      vecs[4] = '{2'b00, 32'h0000_0102, 32'h1234_5678, 32'h0000_0000, 2, 32'h0, 4'b0000};
      vecs[5] = '{2'b10, 32'h0000_0200, 32'h0000_00CD, 32'hAABB_CCDD, 1, 32'hAABB_CCCD, 4'b0001};
      vecs[6] = '{2'b01, 32'h0000_0300, 32'h0000_1234, 32'hAABB_CCDD, 1, 32'hAABB_1234, 4'b0011};
      vecs[7] = '{2'b10, 32'h0000_0201, 32'h0000_0077, 32'h1122_3344, 1, 32'h1122_7744, 4'b0010};
      vecs[8] = '{2'b10, 32'h0000_0202, 32'h0000_0099, 32'h1122_3344, 1, 32'h1199_3344, 4'b0100};
      vecs[9] = '{2'b11, 32'h0000_0100, 32'h0000_0001, 32'h0000_0000, 2, 32'h0, 4'b0000};

      rst_n = 1'b0; req = 1'b0; size = 2'b00; addr = 32'h0; wr_data = 32'h0; mem_rd_data = 32'h0;
      repeat (3) @(posedge clk);
      #2;
      chk("reset_ctrl", {27'h0, busy, mem_read, mem_write, done, align_err}, 32'h0);
      chk("reset_addr", mem_addr, 32'h0);
      chk("reset_wdata", mem_wr_data, 32'h0);
      chk("reset_be", {28'h0, byte_en}, 32'h0);

      // Release reset and present the first store at once: the first rising
      // edge with reset deasserted must accept it.
      rst_n = 1'b1;
      foreach (vecs[i]) begin
         issue(vecs[i]);
         drain($sformatf("vec%0d", i));
      end

      // Abort a byte store with reset while it is in MERGE
      req = 1'b1; size = 2'b10; addr = 32'h0000_0203; wr_data = 32'h0000_00AB;
      mem_rd_data = 32'h1122_3344;
      push(K_READ, cyc + 1, 32'h0000_0200, 32'h0, 4'h0);
      @(posedge clk); #2;         // READ
      req = 1'b0;
      @(posedge clk); #2;         // MERGE
      rst_n = 1'b0;
      #1;
      chk("abort_ctrl", {27'h0, busy, mem_read, mem_write, done, align_err}, 32'h0);
      chk("abort_addr", mem_addr, 32'h0);
      chk("abort_wdata", mem_wr_data, 32'h0);
      chk("abort_be", {28'h0, byte_en}, 32'h0);
      @(posedge clk); #2;
      rst_n = 1'b1;
      repeat (6) begin
         @(posedge clk); #2;      // any write/done here is an unexpected event
      end
      issue('{2'b00, 32'h0000_0600, 32'hCAFE_F00D, 32'h0, 0, 32'hCAFE_F00D, 4'b1111});
      drain("after_reset");

      // Back-to-back word stores with req held; operands change while busy
      begin
         int t;
         req = 1'b1; size = 2'b00; addr = 32'h0000_0400; wr_data = 32'h1111_1111;
         t = cyc + 1;
         push(K_WRITE, t,     32'h0000_0400, 32'h1111_1111, 4'b1111);
         push(K_DONE,  t + 1, 32'h0, 32'h0, 4'h0);
         push(K_WRITE, t + 3, 32'h0000_0500, 32'h2222_2222, 4'b1111);
         push(K_DONE,  t + 4, 32'h0, 32'h0, 4'h0);
         @(posedge clk); #2;      // first accepted
         addr = 32'h0000_0500; wr_data = 32'h2222_2222;
         repeat (3) begin
            @(posedge clk); #2;
         end
         req = 1'b0;              // second accepted on the previous edge
         drain("back_to_back");
      end

      repeat (3) @(posedge clk);
      #2;
      chk("queue_empty", q.size(), 32'h0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire

// File: doc/store_narrow_rmw.md
STORE_NARROW_RMW -- requirements
Module: store_narrow_rmw

Interface
REQ-001 Clk  input  1  sole clock; all state updates on rising edge.
REQ-002 Rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 Req  input  1  store request valid; sampled only while Busy=0.
REQ-004 Size  input  2  00 word, 01 halfword, 10 byte, 11 reserved.
REQ-005 Addr  input  32  byte address of store.
REQ-006 WrData  input  32  register value; halfword uses [15:0], byte uses [7:0].
REQ-007 Busy  output  1  1 = request not accepted; requester holds Req and operands.
REQ-008 MemAddr  output  32  word-aligned address {latched Addr[31:2],2'b00}.
REQ-009 MemRead  output  1  one-cycle read strobe.
REQ-010 MemRdData  input  32  memory read data, valid the cycle after MemRead=1.
REQ-011 MemWrite  output  1  one-cycle write strobe.
REQ-012 MemWrData  output  32  full word to write.
REQ-013 ByteEn  output  4  lanes modified by the current store, valid with MemWrite.
REQ-014 Done  output  1  one-cycle pulse on store completion.
REQ-015 AlignErr  output  1  one-cycle pulse on rejected request.

Function
REQ-016 Byte lane k (k=0..3) SHALL occupy bits [8k+7:8k] (little-endian); halfword at Addr[1] SHALL occupy bits [16*Addr[1]+15:16*Addr[1]].
REQ-017 States SHALL be IDLE, READ, MERGE, WRITE, DONE; Busy=0 only in IDLE.
REQ-018 IDLE with Req=1: Addr, Size, WrData SHALL be latched; all later input changes ignored until return to IDLE.
REQ-019 Accepted word (Addr[1:0]=00): IDLE->WRITE; MemWrData=latched WrData, ByteEn=1111.
REQ-020 Accepted halfword (Addr[0]=0) or byte: IDLE->READ->MERGE->WRITE.
REQ-021 READ: MemRead=1 for exactly one cycle at MemAddr.
REQ-022 MERGE: MemRdData SHALL be captured; target lane(s) replaced by narrowed WrData, other lanes preserved bit-exact.
REQ-023 WRITE: MemWrite=1 for exactly one cycle; MemWrData=merged word; ByteEn=0011/1100 (half at Addr[1]=0/1) or one-hot 1<<Addr[1:0] (byte).
REQ-024 DONE: Done=1 one cycle, then IDLE; new request acceptable the following cycle.
REQ-025 Latency from acceptance edge t: word MemWrite at t+1, Done at t+2; sub-word MemRead at t+1, MemWrite at t+3, Done at t+4.
REQ-026 Misaligned word (Addr[1:0]!=00), misaligned halfword (Addr[0]=1), or Size=11 SHALL NOT be accepted into READ/WRITE: AlignErr=1 in the next cycle, no memory strobes, state stays IDLE, Busy stays 0.
REQ-027 Req while Busy=1 SHALL be ignored, not queued.
REQ-028 MemRead and MemWrite SHALL never be 1 in the same cycle.
REQ-029 MemAddr SHALL hold its value from READ through WRITE; in IDLE it SHALL be 0.
REQ-030 MemWrData and ByteEn SHALL be 0 whenever MemWrite=0.

Reset
REQ-031 Rst=0 SHALL immediately force IDLE and drive Busy, MemRead, MemWrite, Done, AlignErr, ByteEn, MemAddr, MemWrData to 0, and clear latched operands.
REQ-032 Reset mid-operation SHALL abort the store: no subsequent MemWrite or Done for it after Rst returns to 1.
REQ-033 First request SHALL be accepted on the first rising edge with Rst=1.

Verification
REQ-034 Word store Addr=0x100, WrData=0xDEADBEEF -> MemWrite at t+1, MemAddr=0x100, MemWrData=0xDEADBEEF, ByteEn=1111; Done at t+2; MemRead never 1.
REQ-035 Byte store Addr=0x203, WrData=0x000000AB, MemRdData=0x11223344 -> MemRead at t+1, MemWrite at t+3 with MemWrData=0xAB223344, ByteEn=1000; Done at t+4.
REQ-036 Half store Addr=0x302, WrData=0xFFFF5A5A, MemRdData=0x11223344 -> MemWrData=0x5A5A3344, ByteEn=1100.
REQ-037 Half store Addr=0x301 and word store Addr=0x102 -> AlignErr pulse each, no MemRead/MemWrite, Busy stays 0.
REQ-038 Byte store accepted, Rst=0 asserted during MERGE -> all outputs 0 at once; after release, no MemWrite/Done; next word request completes normally.
REQ-039 Req held high across back-to-back word stores -> second accepted the cycle after Done, inputs changed while Busy=1 do not alter first MemWrData.
